id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage RV32I pipeline, directly downstream of the fetch stage. It accepts {instruction, PC} from IF through the valid/allow-in handshake and decodes it. It reads the register file, interlocks on read-after-write hazards against instructions in flight, and resolves branches and jumps. It returns the redirect bus to IF and forwards a decoded bundle to EX.

## Interface
- IF_TO_ID_BUS_WD, 64, width of {instruction[63:32], pc[31:0]} from IF.
- BR_BUS_WD, 33, width of {taken[32], target[31:0]} returned to IF.
- ID_TO_EX_BUS_WD, 142, width of {pc, src1, src2, imm (32 each), rd[4:0], rf_we, op_class[3:0], funct3[2:0], funct7_b5}, msb first.
- Ports, clock and reset first:
- clk  in  1  the single clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- IF_to_ID_Valid  in  1  IF holds a valid instruction.
- IF_to_ID_Bus  in  64  {instruction, pc}.
- ID_Allow_in  out  1  ID can accept this cycle.
- ID_Valid  out  1  ID register holds a live instruction.
- Branch_or_Jump_Bus  out  33  {taken, target} to IF.
- RF_raddr1, RF_raddr2  out  5 each  rs1 and rs2 of the held instruction.
- RF_rdata1, RF_rdata2  in  32 each  combinational register-file read data.
- EX_dest, MEM_dest, WB_dest  in  6 each  {valid, rd} of the instruction in each later stage.
- EX_Allow_in  in  1  EX can accept.
- ID_to_EX_Valid  out  1  bundle valid to EX.
- ID_to_EX_Bus  out  142  decoded bundle.

## Operation
- Registers: ID_Valid and inst/pc (64 bits).
  - Load on IF_to_ID_Valid & ID_Allow_in.
  - If ID_Allow_in is high and IF_to_ID_Valid is low, ID_Valid clears.
- Handshake:
  - ID_Ready = ~stall.
  - ID_Allow_in = ~ID_Valid | (ID_Ready & EX_Allow_in).
  - ID_to_EX_Valid = ID_Valid & ID_Ready.
  - fire = ID_to_EX_Valid & EX_Allow_in.
- op_class encoding: 0 OP, 1 OP-IMM, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR, 6 BRANCH, 7 LOAD, 8 STORE, 15 illegal.
  - Illegal instructions have rf_we = 0 and taken = 0, and still flow to EX.
- imm is sign-extended from the I, S, B, U or J format selected by opcode.
- Use flags:
  - rs1 is used by OP, OP-IMM, JALR, BRANCH, LOAD and STORE.
  - rs2 is used by OP, BRANCH and STORE.
- rf_we = (class in {OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD}) & (rd ≠ 0).
- stall = ID_Valid & any(used rsN ≠ 0 & Xdest.valid & Xdest.rd == rsN), for X in {EX, MEM, WB}. There is no bypassing.
- src1/src2 are 0 when rsN = 0, otherwise RF_rdataN.
  - For JAL and JALR, src2 carries pc+4 as the link value.
- Branch resolution (combinational, from src values):
  - BEQ, BNE, BLT, BGE, BLTU, BGEU are evaluated on 32-bit signed/unsigned compares; the target is pc+imm.
  - JAL target is pc+imm.
  - JALR target is (src1+imm) & ~1.
  - All additions wrap modulo 2^32.
- Branch_or_Jump_Bus.taken = fire & (JAL | JALR | branch condition true). The target field is don't-care when taken = 0.
- ID never discards the instruction behind a taken branch; IF squashes it.

## Timing
- Reset values: ID_Valid 0, inst/pc 0, ID_Allow_in 1, ID_to_EX_Valid 0, taken 0.
  - Reset asserts asynchronously.
  - Reset mid-stall drops the held instruction immediately.
- Latency: an instruction accepted at edge N presents ID_to_EX_Valid during cycle N+1 if there is no hazard.
- Stall: the held instruction and bus stay stable, ID_Allow_in = 0 and ID_to_EX_Valid = 0. It leaves the cycle the hazard clears.
- EX_Allow_in = 0 with no stall: ID_to_EX_Valid stays 1, the bundle is stable, taken stays 0, and ID_Allow_in = 0.
- Redirect is combinational and pulses exactly one cycle per taken instruction, in the fire cycle.
- When fire and accept happen in the same cycle, the new instruction replaces the old at the edge.

## Test plan
- Reset, then a stream of ADDI x1,x0,5 at pc 0x0, 0x4, 0x8 with EX_Allow_in = 1 -> one instruction per cycle; bundle imm = 5, rd = 1, rf_we = 1, class 1.
- ADD x3,x1,x2 with EX_dest = {1,1} for 2 cycles -> ID_Allow_in = 0 and ID_to_EX_Valid = 0 for 2 cycles, then the bundle is issued; RF_raddr1 = 1 and RF_raddr2 = 2 throughout.
- BEQ at pc 0x100, imm 0x20, rdata1 = rdata2 = 7 -> taken pulses 1 for one cycle with target 0x120. With rdata2 = 8 -> taken = 0.
- JALR x1,0(x5), rdata1 = 0x1003 -> target 0x1002, src2 = pc+4.
- BLT vs BLTU with src1 = 0xFFFFFFFF, src2 = 1 -> BLT taken, BLTU not taken.
- EX_Allow_in held 0 for 3 cycles on a JAL -> bundle stable and taken = 0; taken pulses once when EX_Allow_in rises. Then rst = 0 during a stall -> ID_Valid is 0 before the next edge.

Source files
------------

// File: rtl/id_stage_if.sv
// Handshake, register-file and bypass-free hazard signals between the decode stage and its neighbours.
// The slave modport is the decode stage itself; the master modport is the IF/RF/EX environment.
interface id_stage_if;
    logic          IF_to_ID_Valid;
    logic [63:0]   IF_to_ID_Bus;
    logic          ID_Allow_in;
    logic          ID_Valid;
    logic [32:0]   Branch_or_Jump_Bus;
    logic [4:0]    RF_raddr1;
    logic [4:0]    RF_raddr2;
    logic [31:0]   RF_rdata1;
    logic [31:0]   RF_rdata2;
    logic [5:0]    EX_dest;
    logic [5:0]    MEM_dest;
    logic [5:0]    WB_dest;
    logic          EX_Allow_in;
    logic          ID_to_EX_Valid;
    logic [141:0]  ID_to_EX_Bus;

    modport slave (
        input  IF_to_ID_Valid, IF_to_ID_Bus, RF_rdata1, RF_rdata2,
        input  EX_dest, MEM_dest, WB_dest, EX_Allow_in,
        output ID_Allow_in, ID_Valid, Branch_or_Jump_Bus, RF_raddr1, RF_raddr2,
        output ID_to_EX_Valid, ID_to_EX_Bus
    );

    modport master (
        output IF_to_ID_Valid, IF_to_ID_Bus, RF_rdata1, RF_rdata2,
        output EX_dest, MEM_dest, WB_dest, EX_Allow_in,
        input  ID_Allow_in, ID_Valid, Branch_or_Jump_Bus, RF_raddr1, RF_raddr2,
        input  ID_to_EX_Valid, ID_to_EX_Bus
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: holds one instruction, interlocks on RAW hazards (no bypass),
// resolves branches/jumps combinationally and hands a decoded bundle to EX.
module id_stage (
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);
    localparam logic [3:0] CLS_OP    = 4'd0;
    localparam logic [3:0] CLS_OPIMM = 4'd1;
    localparam logic [3:0] CLS_LUI   = 4'd2;
    localparam logic [3:0] CLS_AUIPC = 4'd3;
    localparam logic [3:0] CLS_JAL   = 4'd4;
    localparam logic [3:0] CLS_JALR  = 4'd5;
    localparam logic [3:0] CLS_BR    = 4'd6;
    localparam logic [3:0] CLS_LOAD  = 4'd7;
    localparam logic [3:0] CLS_STORE = 4'd8;
    localparam logic [3:0] CLS_ILL   = 4'd15;

    logic        id_valid_r;
    logic [63:0] inst_pc_r;
    logic [31:0] inst_s, pc_s, imm_s, src1_s, src2_s;
    logic [31:0] pc_plus4_s, target_s;
    logic [6:0]  opcode_s;
    logic [4:0]  rs1_s, rs2_s, rd_s;
    logic [2:0]  funct3_s;
    logic [3:0]  op_class_s;
    logic        use_rs1_s, use_rs2_s, rf_we_s, br_cond_s;
    logic        stall_s, allow_in_s, to_ex_valid_s, fire_s, taken_s;

    // A source register matches a valid, non-x0 destination in a later stage.
    function automatic logic hit_f(input logic [5:0] dest, input logic [4:0] rs);
        return dest[5] & (dest[4:0] == rs) & (rs != 5'd0);
    endfunction

    assign inst_s   = inst_pc_r[63:32];
    assign pc_s     = inst_pc_r[31:0];
    assign opcode_s = inst_s[6:0];
    assign rd_s     = inst_s[11:7];
    assign funct3_s = inst_s[14:12];
    assign rs1_s    = inst_s[19:15];
    assign rs2_s    = inst_s[24:20];

    // Instruction register: accept a new instruction whenever the slot is free or draining.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_r <= 1'b0;
            inst_pc_r  <= 64'd0;
        end else if (allow_in_s) begin
            id_valid_r <= bus.IF_to_ID_Valid;
            if (bus.IF_to_ID_Valid) begin
                inst_pc_r <= bus.IF_to_ID_Bus;
            end
        end
    end

    // Opcode classification, operand-use flags and immediate extraction.
    always_comb begin
        op_class_s = CLS_ILL;
        imm_s      = 32'd0;
        use_rs1_s  = 1'b0;
        use_rs2_s  = 1'b0;
        case (opcode_s)
            7'b0110011: begin op_class_s = CLS_OP; use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
            7'b0010011: begin op_class_s = CLS_OPIMM; use_rs1_s = 1'b1;
                              imm_s = {{20{inst_s[31]}}, inst_s[31:20]}; end
            7'b0110111: begin op_class_s = CLS_LUI; imm_s = {inst_s[31:12], 12'd0}; end
            7'b0010111: begin op_class_s = CLS_AUIPC; imm_s = {inst_s[31:12], 12'd0}; end
            7'b1101111: begin op_class_s = CLS_JAL;
                              imm_s = {{11{inst_s[31]}}, inst_s[31], inst_s[19:12], inst_s[20], inst_s[30:21], 1'b0}; end
            7'b1100111: begin op_class_s = CLS_JALR; use_rs1_s = 1'b1;
                              imm_s = {{20{inst_s[31]}}, inst_s[31:20]}; end
            7'b1100011: begin op_class_s = CLS_BR; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                              imm_s = {{19{inst_s[31]}}, inst_s[31], inst_s[7], inst_s[30:25], inst_s[11:8], 1'b0}; end
            7'b0000011: begin op_class_s = CLS_LOAD; use_rs1_s = 1'b1;
                              imm_s = {{20{inst_s[31]}}, inst_s[31:20]}; end
            7'b0100011: begin op_class_s = CLS_STORE; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                              imm_s = {{20{inst_s[31]}}, inst_s[31:25], inst_s[11:7]}; end
            default:    begin op_class_s = CLS_ILL; end
        endcase
    end

    // Register-writing classes; x0 is never written.
    always_comb begin
        rf_we_s = 1'b0;
        case (op_class_s)
            CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC,
            CLS_JAL, CLS_JALR, CLS_LOAD: rf_we_s = (rd_s != 5'd0);
            default:                     rf_we_s = 1'b0;
        endcase
    end

    // Operand selection; jumps carry the link address in src2.
    always_comb begin
        src1_s = 32'd0;
        src2_s = 32'd0;
        if (rs1_s != 5'd0) begin
            src1_s = bus.RF_rdata1;
        end else begin
            src1_s = 32'd0;
        end
        if ((op_class_s == CLS_JAL) || (op_class_s == CLS_JALR)) begin
            src2_s = pc_plus4_s;
        end else if (rs2_s != 5'd0) begin
            src2_s = bus.RF_rdata2;
        end else begin
            src2_s = 32'd0;
        end
    end

    // Conditional-branch outcome from the selected operands.
    always_comb begin
        br_cond_s = 1'b0;
        case (funct3_s)
            3'b000:  br_cond_s = (src1_s == src2_s);
            3'b001:  br_cond_s = (src1_s != src2_s);
            3'b100:  br_cond_s = ($signed(src1_s) <  $signed(src2_s));
            3'b101:  br_cond_s = ($signed(src1_s) >= $signed(src2_s));
            3'b110:  br_cond_s = (src1_s <  src2_s);
            3'b111:  br_cond_s = (src1_s >= src2_s);
            default: br_cond_s = 1'b0;
        endcase
    end

    // RAW interlock and the IF/EX handshake.
    always_comb begin
        stall_s = 1'b0;
        if (id_valid_r) begin
            stall_s = (use_rs1_s & (hit_f(bus.EX_dest, rs1_s) | hit_f(bus.MEM_dest, rs1_s) | hit_f(bus.WB_dest, rs1_s)))
                    | (use_rs2_s & (hit_f(bus.EX_dest, rs2_s) | hit_f(bus.MEM_dest, rs2_s) | hit_f(bus.WB_dest, rs2_s)));
        end else begin
            stall_s = 1'b0;
        end
        allow_in_s    = ~id_valid_r | (~stall_s & bus.EX_Allow_in);
        to_ex_valid_s = id_valid_r & ~stall_s;
        fire_s        = to_ex_valid_s & bus.EX_Allow_in;
    end

    assign pc_plus4_s = pc_s + 32'd4;
    assign target_s   = (op_class_s == CLS_JALR) ? ((src1_s + imm_s) & 32'hFFFF_FFFE) : (pc_s + imm_s);
    assign taken_s    = fire_s & ((op_class_s == CLS_JAL) | (op_class_s == CLS_JALR)
                                  | ((op_class_s == CLS_BR) & br_cond_s));

    assign bus.ID_Allow_in        = allow_in_s;
    assign bus.ID_Valid           = id_valid_r;
    assign bus.ID_to_EX_Valid     = to_ex_valid_s;
    assign bus.RF_raddr1          = rs1_s;
    assign bus.RF_raddr2          = rs2_s;
    assign bus.Branch_or_Jump_Bus = {taken_s, target_s};
    assign bus.ID_to_EX_Bus       = {pc_s, src1_s, src2_s, imm_s, rd_s, rf_we_s,
                                     op_class_s, funct3_s, inst_s[30]};
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected bundles are queued at drive time and popped
// by a monitor whenever the stage fires into EX.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_if dut_if ();
    id_stage dut (.clk(clk), .rst(rst), .bus(dut_if));

    typedef struct {
        logic [141:0] bus;
        logic         taken;
        logic [31:0]  target;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [141:0] obs, input logic [141:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] imm, input logic [4:0] rd, input logic we,
                        input logic [3:0] cls, input logic [2:0] f3, input logic f7,
                        input logic tk, input logic [31:0] tgt);
        exp_t e;
        e.bus    = {pc, s1, s2, imm, rd, we, cls, f3, f7};
        e.taken  = tk;
        e.target = tgt;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        dut_if.IF_to_ID_Valid = v;
        dut_if.IF_to_ID_Bus   = {inst, pc};
    endtask

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    localparam logic [31:0] ADDI_X1_5 = {12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011};
    localparam logic [31:0] ADD_X3    = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] JALR_X1   = {12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111};

    // Scoreboard: every fire pops one expectation; outside a fire the redirect must be idle.
    always @(negedge clk) begin
        if (rst === 1'b1 && dut_if.ID_to_EX_Valid === 1'b1 && dut_if.EX_Allow_in === 1'b1) begin
            check("fire_expected", 142'(exp_q.size() != 0), 142'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("bundle", dut_if.ID_to_EX_Bus, mon_e.bus);
                check("taken", 142'(dut_if.Branch_or_Jump_Bus[32]), 142'(mon_e.taken));
                if (mon_e.taken) begin
                    check("target", 142'(dut_if.Branch_or_Jump_Bus[31:0]), 142'(mon_e.target));
                end
            end
        end else begin
            check("no_redirect", 142'(dut_if.Branch_or_Jump_Bus[32]), 142'd0);
        end
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        dut_if.RF_rdata1   = 32'd0;
        dut_if.RF_rdata2   = 32'd0;
        dut_if.EX_dest     = 6'd0;
        dut_if.MEM_dest    = 6'd0;
        dut_if.WB_dest     = 6'd0;
        dut_if.EX_Allow_in = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_id_valid", 142'(dut_if.ID_Valid), 142'd0);
        check("rst_allow_in", 142'(dut_if.ID_Allow_in), 142'd1);
        check("rst_to_ex_valid", 142'(dut_if.ID_to_EX_Valid), 142'd0);
        check("rst_taken", 142'(dut_if.Branch_or_Jump_Bus[32]), 142'd0);
        cyc();
        rst = 1'b1;

        // ADDI stream, one per cycle
        dut_if.RF_rdata1 = 32'hDEAD;
        dut_if.RF_rdata2 = 32'h55;
        drive(1'b1, ADDI_X1_5, 32'h0);
        push(32'h0, 32'h0, 32'h55, 32'd5, 5'd1, 1'b1, 4'd1, 3'd0, 1'b0, 1'b0, 32'd0);
        cyc();
        drive(1'b1, ADDI_X1_5, 32'h4);
        push(32'h4, 32'h0, 32'h55, 32'd5, 5'd1, 1'b1, 4'd1, 3'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("addi_latency_valid", 142'(dut_if.ID_to_EX_Valid), 142'd1);
        check("addi_allow_in", 142'(dut_if.ID_Allow_in), 142'd1);
        check("addi_raddr2", 142'(dut_if.RF_raddr2), 142'd5);
        cyc();
        drive(1'b1, ADDI_X1_5, 32'h8);
        push(32'h8, 32'h0, 32'h55, 32'd5, 5'd1, 1'b1, 4'd1, 3'd0, 1'b0, 1'b0, 32'd0);
        cyc();
        drive(1'b0, 32'd0, 32'd0);
        cyc();
        @(negedge clk);
        check("drain_id_valid", 142'(dut_if.ID_Valid), 142'd0);

        // ADD with RAW hazard from EX then WB, released by non-matching dests
        cyc();
        dut_if.RF_rdata1 = 32'd10;
        dut_if.RF_rdata2 = 32'd20;
        dut_if.EX_dest   = 6'b100001;
        drive(1'b1, ADD_X3, 32'h10);
        push(32'h10, 32'd10, 32'd20, 32'd0, 5'd3, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 32'd0);
        cyc();
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check("stall1_allow_in", 142'(dut_if.ID_Allow_in), 142'd0);
        check("stall1_to_ex_valid", 142'(dut_if.ID_to_EX_Valid), 142'd0);
        check("stall1_raddr1", 142'(dut_if.RF_raddr1), 142'd1);
        check("stall1_raddr2", 142'(dut_if.RF_raddr2), 142'd2);
        cyc();
        dut_if.EX_dest = 6'd0;
        dut_if.WB_dest = 6'b100010;
        @(negedge clk);
        check("stall2_allow_in", 142'(dut_if.ID_Allow_in), 142'd0);
        check("stall2_to_ex_valid", 142'(dut_if.ID_to_EX_Valid), 142'd0);
        check("stall2_raddr1", 142'(dut_if.RF_raddr1), 142'd1);
        check("stall2_raddr2", 142'(dut_if.RF_raddr2), 142'd2);
        cyc();
        dut_if.WB_dest  = 6'd0;
        dut_if.MEM_dest = 6'b000001;
        dut_if.EX_dest  = 6'b100011;
        @(negedge clk);
        check("release_to_ex_valid", 142'(dut_if.ID_to_EX_Valid), 142'd1);
        check("release_allow_in", 142'(dut_if.ID_Allow_in), 142'd1);
        cyc();
        dut_if.MEM_dest = 6'd0;
        dut_if.EX_dest  = 6'd0;

        // BEQ taken then not taken, back to back
        dut_if.RF_rdata1 = 32'd7;
        dut_if.RF_rdata2 = 32'd7;
        drive(1'b1, enc_b(13'h20, 5'd2, 5'd1, 3'b000), 32'h100);
        push(32'h100, 32'd7, 32'd7, 32'h20, 5'd0, 1'b0, 4'd6, 3'd0, 1'b0, 1'b1, 32'h120);
        cyc();
        drive(1'b1, enc_b(13'h20, 5'd2, 5'd1, 3'b000), 32'h104);
        push(32'h104, 32'd7, 32'd8, 32'h20, 5'd0, 1'b0, 4'd6, 3'd0, 1'b0, 1'b0, 32'd0);
        cyc();
        dut_if.RF_rdata2 = 32'd8;
        drive(1'b0, 32'd0, 32'd0);
        cyc();

        // JALR x1, 0(x5)
        dut_if.RF_rdata1 = 32'h1003;
        dut_if.RF_rdata2 = 32'd0;
        drive(1'b1, JALR_X1, 32'h200);
        push(32'h200, 32'h1003, 32'h204, 32'd0, 5'd1, 1'b1, 4'd5, 3'd0, 1'b0, 1'b1, 32'h1002);
        cyc();
        drive(1'b0, 32'd0, 32'd0);
        cyc();

        // BLT vs BLTU on 0xFFFFFFFF vs 1
        dut_if.RF_rdata1 = 32'hFFFF_FFFF;
        dut_if.RF_rdata2 = 32'd1;
        drive(1'b1, enc_b(13'h8, 5'd2, 5'd1, 3'b100), 32'h300);
        push(32'h300, 32'hFFFF_FFFF, 32'd1, 32'd8, 5'd8, 1'b0, 4'd6, 3'b100, 1'b0, 1'b1, 32'h308);
        cyc();
        drive(1'b1, enc_b(13'h8, 5'd2, 5'd1, 3'b110), 32'h304);
        push(32'h304, 32'hFFFF_FFFF, 32'd1, 32'd8, 5'd8, 1'b0, 4'd6, 3'b110, 1'b0, 1'b0, 32'd0);
        cyc();
        drive(1'b0, 32'd0, 32'd0);
        cyc();

        // JAL held by EX back-pressure for three cycles
        dut_if.RF_rdata1   = 32'h77;
        dut_if.EX_Allow_in = 1'b0;
        drive(1'b1, enc_jal(21'h40, 5'd1), 32'h400);
        push(32'h400, 32'd0, 32'h404, 32'h40, 5'd1, 1'b1, 4'd4, 3'd0, 1'b0, 1'b1, 32'h440);
        cyc();
        drive(1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_to_ex_valid", 142'(dut_if.ID_to_EX_Valid), 142'd1);
            check("bp_allow_in", 142'(dut_if.ID_Allow_in), 142'd0);
            check("bp_bundle", dut_if.ID_to_EX_Bus, exp_q[0].bus);
            cyc();
        end
        dut_if.EX_Allow_in = 1'b1;
        cyc();

        // Reset asserted in the middle of a stall
        dut_if.EX_dest = 6'b100001;
        drive(1'b1, ADD_X3, 32'h500);
        cyc();
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check("pre_rst_id_valid", 142'(dut_if.ID_Valid), 142'd1);
        check("pre_rst_allow_in", 142'(dut_if.ID_Allow_in), 142'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("async_rst_id_valid", 142'(dut_if.ID_Valid), 142'd0);
        check("async_rst_allow_in", 142'(dut_if.ID_Allow_in), 142'd1);
        check("async_rst_to_ex_valid", 142'(dut_if.ID_to_EX_Valid), 142'd0);
        cyc();
        rst = 1'b1;
        dut_if.EX_dest = 6'd0;
        cyc();
        @(negedge clk);
        check("final_id_valid", 142'(dut_if.ID_Valid), 142'd0);
        check("queue_drained", 142'(exp_q.size()), 142'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
